// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - 2-way set-associative write-through data cache in front of an SRAM controller
// 64 sets of 64-bit blocks, one LRU bit per set, no write-allocate.
module cache_controller #(
    parameter logic [31:0] BASE_ADR = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] adr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        sram_rd_en,
    output logic        sram_wr_en,
    output logic [31:0] sram_adr,
    output logic [31:0] sram_wdata,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

    state_t      state, state_nxt;
    logic [31:0] a;
    logic        word_sel;
    logic [5:0]  idx;
    logic [9:0]  tag;
    logic        unused_a_bits;

    logic        valid_q [2][64];
    logic [9:0]  tag_q   [2][64];
    logic [63:0] blk_q   [2][64];
    logic        lru_q   [64];

    logic        hit0, hit1, hit, hit_way, victim;
    logic [63:0] hit_blk;
    logic        fill_en, wr_hit_en, touch_en;

    assign a             = adr - BASE_ADR;
    assign word_sel      = a[2];
    assign idx           = a[8:3];
    assign tag           = a[18:9];
    assign unused_a_bits = ^{a[31:19], a[1:0]};

    assign sram_adr   = adr;
    assign sram_wdata = wdata;

    // A set never holds the same tag twice, so hit1 alone identifies the hitting way.
    assign hit0    = valid_q[0][idx] && (tag_q[0][idx] == tag);
    assign hit1    = valid_q[1][idx] && (tag_q[1][idx] == tag);
    assign hit     = hit0 || hit1;
    assign hit_way = hit1;
    assign hit_blk = hit_way ? blk_q[1][idx] : blk_q[0][idx];

    // Invalid ways are filled first; with both valid the LRU bit names the victim.
    always_comb begin
        if (!valid_q[0][idx])      victim = 1'b0;
        else if (!valid_q[1][idx]) victim = 1'b1;
        else                       victim = lru_q[idx];
    end

    always_comb begin
        state_nxt  = state;
        ready      = 1'b1;
        rdata      = 32'd0;
        sram_rd_en = 1'b0;
        sram_wr_en = 1'b0;
        fill_en    = 1'b0;
        wr_hit_en  = 1'b0;
        touch_en   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_w_en) begin
                    ready     = 1'b0;
                    state_nxt = WR_THRU;
                    wr_hit_en = hit;
                    touch_en  = hit;
                end else if (mem_r_en) begin
                    if (hit) begin
                        rdata    = word_sel ? hit_blk[63:32] : hit_blk[31:0];
                        touch_en = 1'b1;
                    end else begin
                        ready     = 1'b0;
                        state_nxt = RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                sram_rd_en = 1'b1;
                ready      = sram_ready;
                if (sram_ready) begin
                    rdata     = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
                    fill_en   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WR_THRU: begin
                sram_wr_en = 1'b1;
                ready      = sram_ready;
                if (sram_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            for (int i = 0; i < 64; i++) begin
                valid_q[0][i] <= 1'b0;
                valid_q[1][i] <= 1'b0;
                lru_q[i]      <= 1'b0;
            end
        end else begin
            state <= state_nxt;
            if (fill_en) begin
                valid_q[victim][idx] <= 1'b1;
                lru_q[idx]           <= ~victim;
            end else if (touch_en) begin
                lru_q[idx] <= ~hit_way;
            end
        end
    end

    // Tags and blocks are qualified by valid bits, so they need no reset.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[victim][idx] <= tag;
            blk_q[victim][idx] <= sram_rdata;
        end else if (wr_hit_en) begin
            if (word_sel) blk_q[hit_way][idx][63:32] <= wdata;
            else          blk_q[hit_way][idx][31:0]  <= wdata;
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - self-checking bench for cache_controller against a presence/LRU model and backing memory
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_r_en = 1'b0, mem_w_en = 1'b0;
    logic [31:0] adr = 32'd0, wdata = 32'd0;
    logic [31:0] rdata;
    logic        ready, sram_rd_en, sram_wr_en;
    logic [31:0] sram_adr, sram_wdata;
    logic [63:0] sram_rdata = 64'd0;
    logic        sram_ready = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    cache_controller #(.BASE_ADR(32'd1024)) dut (
        .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .adr(adr), .wdata(wdata), .rdata(rdata), .ready(ready),
        .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en), .sram_adr(sram_adr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready)
    );

    always #5 clk = ~clk;

    // Backing store: written words are remembered, others follow a fixed pattern.
    logic [31:0] mem_word [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] addr);
        if (mem_word.exists(addr)) return mem_word[addr];
        return addr ^ 32'h5A5A_C3C3;
    endfunction

    // Reference model: which tags are resident per set, and which way is least recently used.
    bit       m_valid [2][64];
    bit [9:0] m_tag   [2][64];
    bit       m_lru   [64];

    function automatic int m_set(input logic [31:0] addr);
        logic [31:0] l;
        l = addr - 32'd1024;
        return int'(l[8:3]);
    endfunction

    function automatic bit [9:0] m_tg(input logic [31:0] addr);
        logic [31:0] l;
        l = addr - 32'd1024;
        return l[18:9];
    endfunction

    function automatic int m_find(input logic [31:0] addr);
        int s;
        s = m_set(addr);
        for (int w = 0; w < 2; w++)
            if (m_valid[w][s] && m_tag[w][s] == m_tg(addr)) return w;
        return -1;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 64; s++) begin
            m_valid[0][s] = 0; m_valid[1][s] = 0; m_lru[s] = 0;
        end
    endtask

    task automatic model_read(input logic [31:0] addr);
        int s, w, v;
        s = m_set(addr);
        w = m_find(addr);
        if (w >= 0) begin
            m_lru[s] = (w == 0);
        end else begin
            if (!m_valid[0][s])      v = 0;
            else if (!m_valid[1][s]) v = 1;
            else                     v = int'(m_lru[s]);
            m_valid[v][s] = 1;
            m_tag[v][s]   = m_tg(addr);
            m_lru[s]      = (v == 0);
        end
    endtask

    task automatic model_write(input logic [31:0] addr);
        int w;
        w = m_find(addr);
        if (w >= 0) m_lru[m_set(addr)] = (w == 0);
    endtask

    // Observations from the most recent access.
    bit          obs_first_ready, obs_saw_rd, obs_saw_wr, obs_proto_err, obs_timeout;
    logic [31:0] obs_rdata;
    int          obs_sram_cyc;

    // Drives one request and plays the SRAM side; starts and ends 1 time unit after a rising edge.
    task automatic run_access(input bit wr, input bit rd, input logic [31:0] addr,
                              input logic [31:0] wd, input int lat);
        int  cyc;
        bit  done;
        logic [31:0] blk;
        obs_first_ready = 0; obs_saw_rd = 0; obs_saw_wr = 0;
        obs_proto_err = 0; obs_timeout = 0; obs_rdata = 32'd0; obs_sram_cyc = 0;
        mem_w_en = wr; mem_r_en = rd; adr = addr; wdata = wd; sram_ready = 1'b0;
        blk = addr & ~32'h7;
        cyc = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            if (sram_rd_en || sram_wr_en) begin
                if (sram_rd_en) obs_saw_rd = 1;
                if (sram_wr_en) obs_saw_wr = 1;
                if ((sram_rd_en && sram_wr_en) || sram_adr !== addr || sram_wdata !== wd)
                    obs_proto_err = 1;
                if (obs_sram_cyc >= lat) begin
                    sram_ready = 1'b1;
                    sram_rdata = {mem_rd(blk + 32'd4), mem_rd(blk)};
                    #1;
                end
                obs_sram_cyc++;
            end
            if (ready === 1'b1) begin
                if (cyc == 0) obs_first_ready = 1;
                obs_rdata = rdata;
                done = 1;
            end else if (cyc >= 40) begin
                obs_timeout = 1;
                done = 1;
            end
            cyc++;
            @(posedge clk); #1;
            sram_ready = 1'b0;
        end
        mem_r_en = 1'b0; mem_w_en = 1'b0;
        if (wr) mem_word[addr] = wd;
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b1;
        #12;
        n_vec++; if (ready !== 1'b1)      begin n_err++; $display("FAIL reset_ready got=%b exp=1", ready); end
        n_vec++; if (sram_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en got=%b exp=0", sram_rd_en); end
        n_vec++; if (sram_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got=%b exp=0", sram_wr_en); end
        n_vec++; if (rdata !== 32'd0)     begin n_err++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (ready !== 1'b1)      begin n_err++; $display("FAIL idle_ready got=%b exp=1", ready); end
    endtask

    task automatic test_cold_read();
        mem_word[32'd1024] = 32'hAAAA_0001;
        mem_word[32'd1028] = 32'hBBBB_0002;
        run_access(0, 1, 32'd1024, 32'd0, 2);
        model_read(32'd1024);
        n_vec++; if (obs_first_ready !== 1'b0) begin n_err++; $display("FAIL cold_miss ready0 got=%b exp=0", obs_first_ready); end
        n_vec++; if (obs_sram_cyc != 3)        begin n_err++; $display("FAIL cold_rd_en_cycles got=%0d exp=3", obs_sram_cyc); end
        n_vec++; if (obs_rdata !== 32'hAAAA_0001) begin n_err++; $display("FAIL cold_rdata got=%h exp=AAAA0001", obs_rdata); end
        n_vec++; if (obs_proto_err || obs_timeout) begin n_err++; $display("FAIL cold_proto got=%b%b exp=00", obs_proto_err, obs_timeout); end
        run_access(0, 1, 32'd1024, 32'd0, 0);
        model_read(32'd1024);
        n_vec++; if (obs_first_ready !== 1'b1 || obs_saw_rd) begin n_err++; $display("FAIL rehit got=%b/%b exp=1/0", obs_first_ready, obs_saw_rd); end
        n_vec++; if (obs_rdata !== 32'hAAAA_0001) begin n_err++; $display("FAIL rehit_rdata got=%h exp=AAAA0001", obs_rdata); end
        run_access(0, 1, 32'd1028, 32'd0, 0);
        model_read(32'd1028);
        n_vec++; if (obs_first_ready !== 1'b1 || obs_saw_rd) begin n_err++; $display("FAIL hit1028 got=%b/%b exp=1/0", obs_first_ready, obs_saw_rd); end
        n_vec++; if (obs_rdata !== 32'hBBBB_0002) begin n_err++; $display("FAIL hit1028_rdata got=%h exp=BBBB0002", obs_rdata); end
    endtask

    task automatic test_replacement();
        logic [31:0] seq_adr [5];
        bit          seq_hit [5];
        seq_adr = '{32'd1536, 32'd1024, 32'd2048, 32'd1024, 32'd1536};
        seq_hit = '{0, 1, 0, 1, 0};
        for (int i = 0; i < 5; i++) begin
            run_access(0, 1, seq_adr[i], 32'd0, 1);
            model_read(seq_adr[i]);
            n_vec++; if (obs_first_ready !== seq_hit[i]) begin n_err++; $display("FAIL lru_step%0d hit got=%b exp=%b", i, obs_first_ready, seq_hit[i]); end
            n_vec++; if (obs_rdata !== mem_rd(seq_adr[i])) begin n_err++; $display("FAIL lru_step%0d rdata got=%h exp=%h", i, obs_rdata, mem_rd(seq_adr[i])); end
        end
    endtask

    task automatic test_store();
        run_access(1, 0, 32'd1024, 32'h1234_5678, 1);
        model_write(32'd1024);
        n_vec++; if (obs_first_ready !== 1'b0 || !obs_saw_wr || obs_saw_rd) begin n_err++; $display("FAIL store_hs got=%b%b%b exp=010", obs_first_ready, obs_saw_wr, obs_saw_rd); end
        n_vec++; if (obs_sram_cyc != 2) begin n_err++; $display("FAIL store_wr_cycles got=%0d exp=2", obs_sram_cyc); end
        run_access(0, 1, 32'd1024, 32'd0, 0);
        model_read(32'd1024);
        n_vec++; if (obs_first_ready !== 1'b1 || obs_rdata !== 32'h1234_5678) begin n_err++; $display("FAIL store_readback got=%b/%h exp=1/12345678", obs_first_ready, obs_rdata); end
        run_access(1, 0, 32'd3072, 32'hDEAD_0003, 0);
        model_write(32'd3072);
        run_access(0, 1, 32'd3072, 32'd0, 0);
        model_read(32'd3072);
        n_vec++; if (obs_first_ready !== 1'b0 || !obs_saw_rd) begin n_err++; $display("FAIL no_alloc got=%b/%b exp=0/1", obs_first_ready, obs_saw_rd); end
        n_vec++; if (obs_rdata !== 32'hDEAD_0003) begin n_err++; $display("FAIL no_alloc_rdata got=%h exp=DEAD0003", obs_rdata); end
    endtask

    task automatic test_simultaneous();
        run_access(0, 1, 32'd1028, 32'd0, 0);
        model_read(32'd1028);
        run_access(1, 1, 32'd1028, 32'hCAFE_F00D, 1);
        model_write(32'd1028);
        n_vec++; if (obs_saw_wr !== 1'b1 || obs_saw_rd !== 1'b0 || obs_first_ready !== 1'b0) begin n_err++; $display("FAIL simul got=wr%b rd%b r%b exp=wr1 rd0 r0", obs_saw_wr, obs_saw_rd, obs_first_ready); end
        run_access(0, 1, 32'd1028, 32'd0, 0);
        model_read(32'd1028);
        n_vec++; if (obs_first_ready !== 1'b1 || obs_rdata !== 32'hCAFE_F00D) begin n_err++; $display("FAIL simul_readback got=%b/%h exp=1/CAFEF00D", obs_first_ready, obs_rdata); end
    endtask

    task automatic test_reset_mid_miss();
        int  k;
        mem_r_en = 1'b1; adr = 32'd1064; wdata = 32'd0; sram_ready = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (sram_rd_en !== 1'b1 && k < 6);
        n_vec++; if (sram_rd_en !== 1'b1) begin n_err++; $display("FAIL mid_enter_rd_miss got=%b exp=1", sram_rd_en); end
        rst = 1'b1;
        #1;
        n_vec++; if (sram_rd_en !== 1'b0 || sram_wr_en !== 1'b0) begin n_err++; $display("FAIL mid_abort got=%b%b exp=00", sram_rd_en, sram_wr_en); end
        mem_r_en = 1'b0;
        #1;
        n_vec++; if (ready !== 1'b1 || rdata !== 32'd0) begin n_err++; $display("FAIL mid_reset_idle got=%b/%h exp=1/0", ready, rdata); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        run_access(0, 1, 32'd1024, 32'd0, 0);
        model_read(32'd1024);
        n_vec++; if (obs_first_ready !== 1'b0) begin n_err++; $display("FAIL post_reset_1024 hit got=%b exp=0", obs_first_ready); end
        run_access(0, 1, 32'd1064, 32'd0, 0);
        model_read(32'd1064);
        n_vec++; if (obs_first_ready !== 1'b0) begin n_err++; $display("FAIL post_reset_1064 hit got=%b exp=0", obs_first_ready); end
        n_vec++; if (obs_rdata !== mem_rd(32'd1064)) begin n_err++; $display("FAIL post_reset_1064 rdata got=%h exp=%h", obs_rdata, mem_rd(32'd1064)); end
    endtask

    task automatic test_random();
        logic [31:0] addr, wd, exp_rd;
        bit          wr, rd, exp_hit;
        int          lat;
        for (int i = 0; i < 300; i++) begin
            addr = 32'd1024 + (32'($urandom_range(0, 3)) << 9) + (32'($urandom_range(0, 3)) << 3)
                   + (32'($urandom_range(0, 1)) << 2);
            wr   = ($urandom_range(0, 2) == 0);
            rd   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            wd   = $urandom;
            lat  = $urandom_range(0, 3);
            exp_hit = (m_find(addr) >= 0);
            exp_rd  = mem_rd(addr);
            run_access(wr, rd, addr, wr ? wd : 32'd0, lat);
            n_vec++; if (obs_proto_err || obs_timeout) begin n_err++; $display("FAIL rnd%0d proto got=%b%b exp=00 adr=%h", i, obs_proto_err, obs_timeout, addr); end
            if (wr) begin
                model_write(addr);
                n_vec++; if (obs_first_ready || !obs_saw_wr || obs_saw_rd || obs_sram_cyc != lat + 1) begin
                    n_err++; $display("FAIL rnd%0d store got=r%b wr%b rd%b cyc%0d exp=r0 wr1 rd0 cyc%0d adr=%h", i, obs_first_ready, obs_saw_wr, obs_saw_rd, obs_sram_cyc, lat + 1, addr); end
            end else begin
                model_read(addr);
                n_vec++; if (obs_first_ready !== exp_hit || obs_saw_rd !== !exp_hit || obs_saw_wr) begin
                    n_err++; $display("FAIL rnd%0d hit got=r%b rd%b wr%b exp=r%b rd%b wr0 adr=%h", i, obs_first_ready, obs_saw_rd, obs_saw_wr, exp_hit, !exp_hit, addr); end
                n_vec++; if (obs_rdata !== exp_rd) begin n_err++; $display("FAIL rnd%0d rdata got=%h exp=%h adr=%h", i, obs_rdata, exp_rd, addr); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_replacement();
        test_store();
        test_simultaneous();
        test_reset_mid_miss();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached, vectors=%0d", n_vec);
        $fatal(1);
    end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Parameter: BASE_ADR, 1024, byte address subtracted from adr to form the cache-local address.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 mem_r_en  input  1  load request from the MEM stage.
REQ-005 mem_w_en  input  1  store request from the MEM stage.
REQ-006 adr  input  32  word-aligned byte address.
REQ-007 wdata  input  32  store data.
REQ-008 rdata  output  32  load data; valid when ready=1 and mem_r_en=1.
REQ-009 ready  output  1  0 freezes the pipeline; 1 means the request completes this cycle.
REQ-010 sram_rd_en  output  1  read request to the SRAM controller.
REQ-011 sram_wr_en  output  1  write request to the SRAM controller.
REQ-012 sram_adr  output  32  equals adr, unmodified.
REQ-013 sram_wdata  output  32  equals wdata.
REQ-014 sram_rdata  input  64  64-bit block returned by the SRAM controller.
REQ-015 sram_ready  input  1  SRAM controller done; sampled only while sram_rd_en or sram_wr_en=1.

Function
REQ-016 Local address a = adr - BASE_ADR (32-bit wrap); word select a[2]; index a[8:3] (64 sets); tag a[18:9] (10 bits).
REQ-017 Storage: 2 ways x 64 sets, each entry valid bit, 10-bit tag and 64-bit block; one LRU bit per set (0 = way0 least recently used).
REQ-018 Hit = (valid & tag match) in either way; both ways never hold the same tag for one set.
REQ-019 States: IDLE, RD_MISS, WR_THRU; reset state IDLE.
REQ-020 mem_w_en=1 takes priority over mem_r_en=1; a simultaneous request is treated as a store only.
REQ-021 IDLE, no request: ready=1, sram_rd_en=0, sram_wr_en=0, rdata=0.
REQ-022 IDLE read hit: rdata = block word selected by a[2] combinationally, ready=1, zero-cycle latency; LRU bit of the set points to the other way after the edge.
REQ-023 IDLE read miss: ready=0; next state RD_MISS.
REQ-024 RD_MISS: sram_rd_en=1; ready=0 while sram_ready=0.
REQ-025 RD_MISS with sram_ready=1: rdata = sram_rdata word selected by a[2]; ready=1; at the edge the victim way is filled (valid=1, tag, block) and LRU points away from it; next state IDLE.
REQ-026 Victim selection: invalid way0 first, else invalid way1, else the way indicated by LRU.
REQ-027 Store policy: write-through, no write-allocate.
REQ-028 IDLE store: ready=0; next state WR_THRU; on a store hit the selected 32-bit word of the hitting way is updated at that edge and LRU updated; on a miss the cache is untouched.
REQ-029 WR_THRU: sram_wr_en=1 until sram_ready=1; ready=1 in the sram_ready cycle; next state IDLE.
REQ-030 sram_rd_en and sram_wr_en are never both 1.
REQ-031 Requesters hold adr, wdata, mem_r_en and mem_w_en stable while ready=0; behaviour otherwise is undefined.

Reset
REQ-032 rst=1: state IDLE, all valid bits 0, all LRU bits 0, sram_rd_en=0, sram_wr_en=0, ready=1 with no request.
REQ-033 Reset during RD_MISS or WR_THRU aborts the operation; no line is filled and SRAM requests drop immediately.

Verification
REQ-034 Cold read adr=1024: RD_MISS, sram_rd_en until sram_ready; sram_rdata=64'hBBBB_0002_AAAA_0001 -> rdata=AAAA_0001; repeat read -> hit, ready=1 same cycle.
REQ-035 Read adr=1028 after REQ-034 -> hit without SRAM access, rdata=BBBB_0002.
REQ-036 Fill way0 and way1 of set 0 (adr 1024, 1536), read 1024, then miss on 2048 -> way1 (LRU) replaced; 1024 still hits, 1536 misses.
REQ-037 Store wdata=32'h1234_5678 to cached adr 1024 -> sram_wr_en until sram_ready, then read 1024 hits with 1234_5678; store to uncached 3072 -> subsequent read 3072 misses.
REQ-038 Simultaneous mem_r_en=mem_w_en=1 -> store-only handling; rst asserted mid-RD_MISS -> all subsequent reads miss.
